// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Two-port arbiter in front of a single-ported data memory.
//               Grants are Moore outputs of a three-state FSM (IDLE, OWN0,
//               OWN1). A tenure lasts up to MAX_BURST accepted accesses while
//               the other port waits; with no contender the owner keeps the
//               memory without a bubble. Read data is captured from the
//               memory's combinational read port and presented one cycle
//               later with a single-cycle valid pulse.
// Ports       : clk, rst_n (sync, active-low)
//               req*_i / wen*_i / addr*_i / wdata*_i : requester side
//               gnt*_o / rdata*_o / rvalid*_o        : requester responses
//               mem_wen_o / mem_addr_o / mem_wdata_o : memory request
//               mem_rdata_i                          : memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              wen0_i,
    input  logic              wen1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Counter value at which the current accepted access completes a tenure.
    localparam logic [3:0] C_CNT_LAST = 4'(MAX_BURST - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_owner_q, last_owner_d;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic w_acc0, w_acc1;
    logic w_rd0, w_rd1;

    assign w_acc0 = req0_i && (state_q == OWN0);
    assign w_acc1 = req1_i && (state_q == OWN1);
    assign w_rd0  = w_acc0 && !wen0_i;
    assign w_rd1  = w_acc1 && !wen1_i;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                // Tie goes to the port that did not own the memory last.
                if (req0_i && req1_i)
                    state_d = last_owner_q ? OWN0 : OWN1;
                else if (req0_i)
                    state_d = OWN0;
                else if (req1_i)
                    state_d = OWN1;
            end
            OWN0: begin
                if (!req0_i)
                    state_d = req1_i ? OWN1 : IDLE;
                else if (cnt_q == C_CNT_LAST) begin
                    // Tenure exhausted: hand over only if someone is waiting.
                    if (req1_i)
                        state_d = OWN1;
                    else
                        cnt_d = '0;
                end else
                    cnt_d = cnt_q + 4'd1;
            end
            OWN1: begin
                if (!req1_i)
                    state_d = req0_i ? OWN0 : IDLE;
                else if (cnt_q == C_CNT_LAST) begin
                    if (req0_i)
                        state_d = OWN0;
                    else
                        cnt_d = '0;
                end else
                    cnt_d = cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            cnt_d = '0;
        if ((state_d == OWN0) && (state_q != OWN0))
            last_owner_d = 1'b0;
        if ((state_d == OWN1) && (state_q != OWN1))
            last_owner_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_owner_q <= 1'b1;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            rvalid0_q    <= w_rd0;
            rvalid1_q    <= w_rd1;
            if (w_rd0)
                rdata0_q <= mem_rdata_i;
            if (w_rd1)
                rdata1_q <= mem_rdata_i;
        end
    end

    assign gnt0_o    = (state_q == OWN0);
    assign gnt1_o    = (state_q == OWN1);
    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;

    assign mem_wen_o   = (w_acc0 && wen0_i) || (w_acc1 && wen1_i);
    assign mem_addr_o  = (state_q == OWN0) ? addr0_i  :
                         (state_q == OWN1) ? addr1_i  : '0;
    assign mem_wdata_o = (state_q == OWN0) ? wdata0_i :
                         (state_q == OWN1) ? wdata1_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Directed self-checking bench for data_mem_arbiter with a
//               behavioural memory (synchronous write, combinational read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, wen0, wen1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_wen;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_wen)
            mem[mem_addr] <= mem_wdata;

    assign mem_rdata = mem[mem_addr];

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_i      (req0),
        .req1_i      (req1),
        .wen0_i      (wen0),
        .wen1_i      (wen1),
        .addr0_i     (addr0),
        .addr1_i     (addr1),
        .wdata0_i    (wdata0),
        .wdata1_i    (wdata1),
        .gnt0_o      (gnt0),
        .gnt1_o      (gnt1),
        .rdata0_o    (rdata0),
        .rdata1_o    (rdata1),
        .rvalid0_o   (rvalid0),
        .rvalid1_o   (rvalid1),
        .mem_wen_o   (mem_wen),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; wen0 = 0; wen1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0, mem_wen, rvalid1, rvalid0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {gnt1, gnt0, mem_wen, rvalid1, rvalid0});
        end
        checks++;
        if ({rdata1, rdata0, mem_addr} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 000000", {rdata1, rdata0, mem_addr});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        @(posedge clk); #1;
        req0 = 1; wen0 = 0; addr0 = 8'h10;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL read_latency: gnt0 got %b expected 0", gnt0);
        end
        @(negedge clk);
        checks++;
        if ({gnt0, mem_addr} !== {1'b1, 8'h10}) begin
            errors++;
            $display("FAIL read_grant: got %b/%h expected 1/10", gnt0, mem_addr);
        end
        @(posedge clk); #1;
        req0 = 0;
        @(negedge clk);
        checks++;
        if ({rvalid0, rdata0} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL read_data: got %b/%h expected 1/a5", rvalid0, rdata0);
        end
        @(negedge clk);
        checks++;
        if ({gnt0, rvalid0, rdata0} !== {2'b00, 8'hA5}) begin
            errors++;
            $display("FAIL read_hold: got %b%b/%h expected 00/a5", gnt0, rvalid0, rdata0);
        end
    endtask

    task automatic test_arb();
        logic [1:0] exp_g [9];
        logic [7:0] exp_a;
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        @(posedge clk); #1;
        req0 = 1; wen0 = 0; addr0 = 8'h01;
        req1 = 1; wen1 = 0; addr1 = 8'h02;
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0} !== 2'b00) begin
            errors++;
            $display("FAIL arb_idle: got %b expected 00", {gnt1, gnt0});
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            exp_a = exp_g[i][0] ? 8'h01 : 8'h02;
            checks++;
            if ({gnt1, gnt0, mem_addr} !== {exp_g[i], exp_a}) begin
                errors++;
                $display("FAIL arb_cycle%0d: got %b/%h expected %b/%h", i, {gnt1, gnt0}, mem_addr, exp_g[i], exp_a);
            end
        end
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_burst();
        @(posedge clk); #1;
        req1 = 1; wen1 = 0; addr1 = 8'h30;
        @(negedge clk);
        checks++;
        if (gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL burst_latency: gnt1 got %b expected 0", gnt1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({gnt1, gnt0, rvalid1} !== {2'b10, (i > 0)}) begin
                errors++;
                $display("FAIL burst_cycle%0d: got %b expected %b", i, {gnt1, gnt0, rvalid1}, {2'b10, (i > 0)});
            end
        end
        @(posedge clk); #1;
        req1 = 0;
        @(negedge clk);
        checks++;
        if ({rvalid1, rdata1} !== {1'b1, 8'h77}) begin
            errors++;
            $display("FAIL burst_last: got %b/%h expected 1/77", rvalid1, rdata1);
        end
        @(negedge clk);
        checks++;
        if ({gnt1, rvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL burst_end: got %b expected 00", {gnt1, rvalid1});
        end
    endtask

    task automatic test_write_read();
        int wcount = 0;
        @(posedge clk); #1;
        req0 = 1; wen0 = 1; addr0 = 8'h20; wdata0 = 8'h3C;
        req1 = 1; wen1 = 0; addr1 = 8'h20;
        @(negedge clk);
        wcount += int'(mem_wen);
        checks++;
        if ({gnt1, gnt0, mem_wen} !== 3'b000) begin
            errors++;
            $display("FAIL wr_idle: got %b expected 000", {gnt1, gnt0, mem_wen});
        end
        @(negedge clk);
        wcount += int'(mem_wen);
        checks++;
        if ({gnt1, gnt0, mem_wen, mem_addr, mem_wdata} !== {3'b011, 8'h20, 8'h3C}) begin
            errors++;
            $display("FAIL wr_issue: got %b/%h/%h expected 011/20/3c", {gnt1, gnt0, mem_wen}, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        req0 = 0;
        @(negedge clk);
        wcount += int'(mem_wen);
        checks++;
        if ({gnt0, mem_wen, rvalid0, rdata0} !== {3'b100, 8'h01}) begin
            errors++;
            $display("FAIL wr_no_rvalid: got %b/%h expected 100/01", {gnt0, mem_wen, rvalid0}, rdata0);
        end
        @(negedge clk);
        wcount += int'(mem_wen);
        checks++;
        if ({gnt1, gnt0, mem_addr} !== {2'b10, 8'h20}) begin
            errors++;
            $display("FAIL rd_grant: got %b/%h expected 10/20", {gnt1, gnt0}, mem_addr);
        end
        @(posedge clk); #1;
        req1 = 0;
        @(negedge clk);
        wcount += int'(mem_wen);
        checks++;
        if ({rvalid1, rdata1} !== {1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL rd_after_wr: got %b/%h expected 1/3c", rvalid1, rdata1);
        end
        checks++;
        if (wcount !== 1) begin
            errors++;
            $display("FAIL wen_cycles: got %0d expected 1", wcount);
        end
        @(negedge clk);
    endtask

    task automatic test_drop();
        @(posedge clk); #1;
        req0 = 1; wen0 = 0; addr0 = 8'h10;
        req1 = 1; wen1 = 0; addr1 = 8'h30;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0} !== 2'b01) begin
            errors++;
            $display("FAIL drop_own0a: got %b expected 01", {gnt1, gnt0});
        end
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0} !== 2'b01) begin
            errors++;
            $display("FAIL drop_own0b: got %b expected 01", {gnt1, gnt0});
        end
        @(posedge clk); #1;
        req0 = 0;
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0, rvalid0, rdata0} !== {3'b011, 8'hA5}) begin
            errors++;
            $display("FAIL drop_last0: got %b/%h expected 011/a5", {gnt1, gnt0, rvalid0}, rdata0);
        end
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0} !== 2'b10) begin
            errors++;
            $display("FAIL drop_handover: got %b expected 10", {gnt1, gnt0});
        end
        @(posedge clk); #1;
        req1 = 0;
        @(negedge clk);
        checks++;
        if ({rvalid1, rdata1} !== {1'b1, 8'h77}) begin
            errors++;
            $display("FAIL drop_read1: got %b/%h expected 1/77", rvalid1, rdata1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        req1 = 1; wen1 = 0; addr1 = 8'h10;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({gnt1, rdata1} !== {1'b1, 8'h77}) begin
            errors++;
            $display("FAIL rstmid_pre: got %b/%h expected 1/77", gnt1, rdata1);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req1 = 0;
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0, rvalid1, mem_wen, rdata1} !== {4'b0000, 8'h00}) begin
            errors++;
            $display("FAIL rstmid_abort: got %b/%h expected 0000/00", {gnt1, gnt0, rvalid1, mem_wen}, rdata1);
        end
        @(negedge clk);
        checks++;
        if ({gnt1, rvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_after: got %b expected 00", {gnt1, rvalid1});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 8'(i);
        mem[8'h10] = 8'hA5;
        mem[8'h20] = 8'h00;
        mem[8'h30] = 8'h77;

        test_reset();
        test_read();
        do_reset();
        test_arb();
        test_single_burst();
        test_write_read();
        test_drop();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, address width.
REQ-002 SHALL have parameter: DATA_W, 8, data width.
REQ-003 SHALL have parameter: MAX_BURST, 4, maximum consecutive accepted transactions per tenure while the other port waits (legal range 1..15).
REQ-004 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: req0/req1  in  1  requester N wants a memory access.
REQ-007 SHALL have ports: wen0/wen1  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports: addr0/addr1  in  ADDR_W  access address.
REQ-009 SHALL have ports: wdata0/wdata1  in  DATA_W  write data.
REQ-010 SHALL have ports: gnt0/gnt1  out  1  port N owns the memory this cycle.
REQ-011 SHALL have ports: rdata0/rdata1  out  DATA_W  registered read data.
REQ-012 SHALL have ports: rvalid0/rvalid1  out  1  rdataN valid (one-cycle pulse).
REQ-013 SHALL have port: mem_wen  out  1  write enable to the data memory.
REQ-014 SHALL have port: mem_addr  out  ADDR_W  memory address.
REQ-015 SHALL have port: mem_wdata  out  DATA_W  memory write data.
REQ-016 SHALL have port: mem_rdata  in  DATA_W  combinational read data from the memory.

Function
REQ-017 SHALL implement FSM states IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1); grants are Moore outputs, never both high.
REQ-018 SHALL count an access as accepted in any cycle where reqN && gntN; requesters hold req/wen/addr/wdata stable until accepted.
REQ-019 SHALL, in IDLE: only req0 -> OWN0; only req1 -> OWN1; both -> port != last_owner; neither -> stay IDLE.
REQ-020 SHALL, in OWNn with reqn low: go to the other OWN state if the other req is high, else IDLE.
REQ-021 SHALL keep a tenure counter incremented per accepted access and cleared on every state change.
REQ-022 SHALL, when an access is accepted with the counter at MAX_BURST-1 and the other req high, switch to the other OWN state next cycle.
REQ-023 SHALL, when an access is accepted with the counter at MAX_BURST-1 and the other req low, stay in OWNn and clear the counter (no wasted cycle).
REQ-024 SHALL update last_owner to n on every entry into OWNn.
REQ-025 SHALL drive mem_addr/mem_wdata from the owning port, and all zeros in IDLE.
REQ-026 SHALL drive mem_wen = reqn && gntn && wenn for the owner, combinationally, and 0 otherwise.
REQ-027 SHALL, on an accepted read, register mem_rdata into rdataN at that edge and pulse rvalidN high for exactly the next cycle; rdataN holds its value afterward.
REQ-028 SHALL, on an accepted write, leave rvalidN low and rdataN unchanged.
REQ-029 SHALL impose a one-cycle latency from req rising in IDLE to the first grant, and zero bubble cycles for back-to-back accesses within a tenure.
REQ-030 SHALL tolerate a same-address write by one port followed immediately by a read from the other: the read returns the newly written data, guaranteed by the memory's synchronous write.

Reset
REQ-031 SHALL, when rst_n is low at a clock edge: state=IDLE, last_owner=1 (port0 wins the first tie), counter=0, rvalid0/1=0, rdata0/1=0.
REQ-032 SHALL make gnt0/1 and mem_wen low in the cycle after a reset edge; a reset mid-tenure aborts the tenure, and any access accepted on the same edge as reset is discarded with no rvalid.

Verification
REQ-033 SHALL pass: after reset, req0=1, wen0=0, addr0=0x10 with mem[0x10]=0xA5 -> gnt0 high next cycle; rdata0=0xA5 and rvalid0=1 one cycle after acceptance.
REQ-034 SHALL pass: req0 and req1 both rising from IDLE after reset -> OWN0 first; with MAX_BURST=4 and both held, grant pattern is 0,0,0,0,1,1,1,1,0 ...
REQ-035 SHALL pass: req1 alone, held for 10 accesses -> gnt1 continuous for 10 cycles, no bubble at counter wrap.
REQ-036 SHALL pass: port0 writes 0x3C to 0x20, then port1 reads 0x20 -> mem_wen=1 for exactly one cycle; rdata1=0x3C with rvalid1 pulse.
REQ-037 SHALL pass: rst_n low during OWN1 with a read accepted on the same edge -> next cycle state IDLE, gnt1=0, rvalid1=0, rdata1=0x00.
REQ-038 SHALL pass: port0 drops req mid-tenure while req1 is high -> OWN1 next cycle; no cycle with both grants high.
